alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU (3-bit op, signed lhs/rhs, signed result) between two requesters.
- Each requester presents an operation over a valid/ready handshake. The block round-robin arbitrates, drives the ALU, and captures the result in a one-entry output register.
- The result is returned over a valid/ready response channel tagged with the requester id.
- Sits between the decode/issue stages and the ALU. It owns the ALU's op/lhs/rhs inputs exclusively.

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter_if : request/response bundle for the two-requester ALU arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
);
  logic                    req0_valid;
  logic                    req0_ready;
  logic [OPW-1:0]          req0_op;
  logic signed [WIDTH-1:0] req0_lhs;
  logic signed [WIDTH-1:0] req0_rhs;

  logic                    req1_valid;
  logic                    req1_ready;
  logic [OPW-1:0]          req1_op;
  logic signed [WIDTH-1:0] req1_lhs;
  logic signed [WIDTH-1:0] req1_rhs;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic signed [WIDTH-1:0] rsp_result;
  logic                    rsp_id;
  logic [CNTW-1:0]         op_count;

  modport master (
    output req0_valid, req0_op, req0_lhs, req0_rhs,
    output req1_valid, req1_op, req1_lhs, req1_rhs,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_id, op_count
  );

  modport slave (
    input  req0_valid, req0_op, req0_lhs, req0_rhs,
    input  req1_valid, req1_op, req1_lhs, req1_rhs,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_id, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one combinational ALU between two
//               requesters, with a one-entry registered response.
// Rev 1.0
// ----------------------------------------------------------------------------

module alu_arbiter_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  wire logic [OPW-1:0]          op,
  input  wire logic signed [WIDTH-1:0] lhs,
  input  wire logic signed [WIDTH-1:0] rhs,
  output      logic signed [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);

  always_comb begin
    result = '0;
    case (op)
      3'd0:    result = lhs + rhs;
      3'd1:    result = lhs - rhs;
      3'd2:    result = lhs & rhs;
      3'd3:    result = lhs | rhs;
      3'd4:    result = lhs << rhs[SHW-1:0];
      3'd5:    result = lhs >> rhs[SHW-1:0];
      3'd6:    result = lhs >>> rhs[SHW-1:0];
      default: result = lhs ^ rhs;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input wire logic   clk,
  input wire logic   rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    id_q, id_d;
  logic [CNTW-1:0]         count_q, count_d;

  logic                    can_accept;
  logic                    grant_vld;
  logic                    grant_id;
  logic                    accept;
  logic [OPW-1:0]          alu_op;
  logic signed [WIDTH-1:0] alu_lhs;
  logic signed [WIDTH-1:0] alu_rhs;
  logic signed [WIDTH-1:0] alu_result;

  // Contention goes to whichever requester was not served last.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign can_accept = !rst && ((state_q == S_EMPTY) || bus.rsp_ready);
  assign accept     = can_accept && grant_vld;

  assign bus.req0_ready = can_accept && grant_vld && !grant_id;
  assign bus.req1_ready = can_accept && grant_vld &&  grant_id;

  always_comb begin
    alu_op  = '0;
    alu_lhs = '0;
    alu_rhs = '0;
    if (grant_vld) begin
      if (grant_id) begin
        alu_op  = bus.req1_op;
        alu_lhs = bus.req1_lhs;
        alu_rhs = bus.req1_rhs;
      end else begin
        alu_op  = bus.req0_op;
        alu_lhs = bus.req0_lhs;
        alu_rhs = bus.req0_rhs;
      end
    end
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op     (alu_op),
    .lhs    (alu_lhs),
    .rhs    (alu_rhs),
    .result (alu_result)
  );

  // An accept overrides a same-cycle drain, giving back-to-back results.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    id_d         = id_q;
    count_d      = count_q;
    if (accept) begin
      state_d      = S_FULL;
      last_grant_d = grant_id;
      result_d     = alu_result;
      id_d         = grant_id;
      count_d      = count_q + CNTW'(1);
    end else if ((state_q == S_FULL) && bus.rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      id_q         <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      id_q         <= id_d;
      count_q      <= count_d;
    end
  end

  assign bus.rsp_valid  = (state_q == S_FULL);
  assign bus.rsp_result = result_q;
  assign bus.rsp_id     = id_q;
  assign bus.op_count   = count_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_arbiter : directed bench for alu_arbiter (16-bit and 4-bit counters)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   failed;

  alu_arbiter_if #(.WIDTH(16), .OPW(3), .CNTW(16)) bus  ();
  alu_arbiter_if #(.WIDTH(16), .OPW(3), .CNTW(4))  bus4 ();

  alu_arbiter #(.WIDTH(16), .OPW(3), .CNTW(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_arbiter #(.WIDTH(16), .OPW(3), .CNTW(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst    = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd7; bus.req0_lhs = 16'sd5; bus.req0_rhs = 16'sd3;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_lhs = 16'sd0; bus.req1_rhs = 16'sd0;
    bus.rsp_ready  = 1'b1;
    bus4.req0_valid = 1'b0; bus4.req0_op = 3'd7; bus4.req0_lhs = 16'sd1; bus4.req0_rhs = 16'sd2;
    bus4.req1_valid = 1'b0; bus4.req1_op = 3'd0; bus4.req1_lhs = 16'sd0; bus4.req1_rhs = 16'sd0;
    bus4.rsp_ready  = 1'b1;

    // Reset with a request pending: nothing accepted.
    tick();
    tick();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_op_count", bus.op_count, 0);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    tick();
    chk("post_rst_op_count", bus.op_count, 0);

    // Single xor through requester 0.
    bus.req0_valid = 1'b1;
    #1;
    chk("xor_req0_ready", bus.req0_ready, 1);
    chk("xor_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("xor_rsp_valid", bus.rsp_valid, 1);
    chk("xor_rsp_result", bus.rsp_result, 6);
    chk("xor_rsp_id", bus.rsp_id, 0);
    chk("xor_op_count", bus.op_count, 1);
    tick();
    chk("drain_rsp_valid", bus.rsp_valid, 0);
    chk("drain_hold_result", bus.rsp_result, 6);
    chk("drain_op_count", bus.op_count, 1);

    // Contention after reset: 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd7; bus.req0_lhs = 16'sd1; bus.req0_rhs = 16'sd2;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd7; bus.req1_lhs = 16'sd4; bus.req1_rhs = 16'sd8;
    bus.rsp_ready  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_req0_ready", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_req1_ready", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("cont_rsp_id", bus.rsp_id, i % 2);
      chk("cont_rsp_result", bus.rsp_result, (i % 2 == 1) ? 12 : 3);
      chk("cont_op_count", bus.op_count, i + 1);
    end

    // Backpressure for 3 cycles, then release with drain+accept.
    bus.rsp_ready = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_req1_ready", bus.req1_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_result", bus.rsp_result, 12);
      chk("bp_rsp_id", bus.rsp_id, 1);
      tick();
    end
    chk("bp_op_count", bus.op_count, 4);
    bus.rsp_ready = 1'b1;
    #1;
    chk("rel_req0_ready", bus.req0_ready, 1);
    chk("rel_req1_ready", bus.req1_ready, 0);
    tick();
    chk("rel_rsp_valid", bus.rsp_valid, 1);
    chk("rel_rsp_id", bus.rsp_id, 0);
    chk("rel_rsp_result", bus.rsp_result, 3);
    chk("rel_op_count", bus.op_count, 5);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("rel_drain_valid", bus.rsp_valid, 0);

    // Xor sweep through requester 1 from a fresh counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'd7;
    for (int l = 2; l <= 29; l++) begin
      for (int r = 2; r <= 29; r++) begin
        bus.req1_lhs = 16'(l);
        bus.req1_rhs = 16'(r);
        tick();
        chk("sweep_result", bus.rsp_result, l ^ r);
        chk("sweep_id", bus.rsp_id, 1);
      end
    end
    chk("sweep_op_count", bus.op_count, 784);

    // Reset while stalled with a held result.
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    tick();
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_op_count", bus.op_count, 0);
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_lhs = 16'sd9; bus.req0_rhs = 16'sd1;
    bus.req1_valid = 1'b1;
    #1;
    chk("midrst_req0_ready", bus.req0_ready, 1);
    chk("midrst_req1_ready", bus.req1_ready, 0);
    tick();
    chk("midrst_rsp_id", bus.rsp_id, 0);
    chk("midrst_rsp_result", bus.rsp_result, 8);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // 4-bit counter wraps after 16 accepts.
    bus4.req0_valid = 1'b1;
    repeat (16) tick();
    chk("wrap16_op_count", bus4.op_count, 0);
    tick();
    bus4.req0_valid = 1'b0;
    chk("wrap17_op_count", bus4.op_count, 1);
    chk("wrap17_rsp_result", bus4.rsp_result, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
